tilelink_uart_tx: RTL and testbench

- TileLink-UL responder peripheral that accepts byte writes from the pinwheel core's data bus and serializes them onto a UART TX line (8N1).
- Sits beside the data RAM and debug register on the core bus, decoded by address tag.
- Its `bus_tld` is OR-merged into the core's read data like the other responders.
- Contains a byte FIFO and a bit-timed transmit FSM.

---
 rtl/uart_tx_pkg.sv | 48 ++++
 rtl/sync_fifo.sv | 53 +++++
 rtl/tilelink_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_tilelink_uart_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the TileLink-UL UART transmitter.
// UART_TX_PARITY_EN adds the even-parity state to the TX FSM.
package uart_tx_pkg;

   typedef struct packed {
      logic [2:0]  a_opcode;
      logic [31:0] a_address;
      logic [31:0] a_data;
      logic [3:0]  a_mask;
      logic        a_valid;
   } tilelink_a;

   typedef struct packed {
      logic [2:0]  d_opcode;
      logic [31:0] d_data;
      logic        d_valid;
   } tilelink_d;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } tx_state_e;

   localparam logic [2:0] OpPutFullData    = 3'd0;
   localparam logic [2:0] OpPutPartialData = 3'd1;
   localparam logic [2:0] OpGet            = 3'd4;
   localparam logic [2:0] OpAccessAck      = 3'd0;
   localparam logic [2:0] OpAccessAckData  = 3'd1;

   localparam logic [1:0] RegTxData = 2'd0;
   localparam logic [1:0] RegStatus = 2'd1;

   localparam int unsigned StatEmpty    = 0;
   localparam int unsigned StatFull     = 1;
   localparam int unsigned StatActive   = 2;
   localparam int unsigned StatOverflow = 3;
   localparam int unsigned StatCountLsb = 8;

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned width = 8,
   parameter int unsigned depth = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [width-1:0]         wdata,
   output logic [width-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(depth):0]   count
);

   localparam int unsigned aw = $clog2(depth);

   logic [width-1:0] mem_q [depth];
   logic [aw-1:0]    wr_ptr_q, rd_ptr_q;
   logic [aw:0]      count_q;
   logic             do_push, do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + aw'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + aw'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (aw+1)'(1);
            2'b01:   count_q <= count_q - (aw+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == (aw+1)'(depth));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/tilelink_uart_tx.sv
// TileLink-UL responder that queues written bytes and shifts them out as 8N1 UART frames.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module tilelink_uart_tx
   import uart_tx_pkg::*;
#(
   parameter logic [31:0] addr_mask    = 32'hF000_0000,
   parameter logic [31:0] addr_tag     = 32'h4000_0000,
   parameter int unsigned clks_per_bit = 4,
   parameter int unsigned fifo_depth   = 8
) (
   input  logic      clock,
   input  logic      tick_reset_in,
   input  tilelink_a tick_tla,
   output tilelink_d bus_tld,
   output logic      ser_tx,
   output logic      tx_busy
);

   localparam int unsigned cw       = $clog2(fifo_depth) + 1;
   localparam logic [15:0] bit_last = 16'(clks_per_bit - 1);

   logic          hit, is_put, is_get, push, pop, full, empty, overflow_q;
   logic [1:0]    offset;
   logic [7:0]    fifo_rdata, count8;
   logic [cw-1:0] count;
   logic [31:0]   status, rdata;
   tilelink_d     tld_q;
   tx_state_e     state_q;
   logic [15:0]   timer_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic          ser_tx_q;
`ifdef UART_TX_PARITY_EN
   logic          parity_q;
`endif
   logic          unused_bits;

   assign unused_bits = ^{tick_tla.a_data[31:8], tick_tla.a_data[6:4], tick_tla.a_data[2:0],
                          tick_tla.a_mask[3:1]};

   assign hit    = tick_tla.a_valid && ((tick_tla.a_address & addr_mask) == addr_tag);
   assign offset = tick_tla.a_address[3:2];
   assign is_put = (tick_tla.a_opcode == OpPutFullData) ||
                   (tick_tla.a_opcode == OpPutPartialData);
   assign is_get = (tick_tla.a_opcode == OpGet);
   assign push   = hit && is_put && (offset == RegTxData) && tick_tla.a_mask[0];
   // Pop on an idle FIFO check or at the last stop-bit cycle so frames abut.
   assign pop    = !empty && ((state_q == StIdle) || ((state_q == StStop) && (timer_q == '0)));

   sync_fifo #(
      .width (8),
      .depth (fifo_depth)
   ) u_fifo (
      .clock (clock),
      .reset (tick_reset_in),
      .push  (push),
      .pop   (pop),
      .wdata (tick_tla.a_data[7:0]),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign count8 = 8'(count);

   always_comb begin
      status                        = '0;
      status[StatEmpty]             = empty;
      status[StatFull]              = full;
      status[StatActive]            = (state_q != StIdle);
      status[StatOverflow]          = overflow_q;
      status[StatCountLsb +: 8]     = count8;
      rdata = '0;
      if (is_get && (offset == RegStatus)) rdata = status;
   end

   always_ff @(posedge clock) begin
      if (tick_reset_in) begin
         tld_q <= '0;
      end else begin
         tld_q.d_valid  <= hit;
         tld_q.d_opcode <= (hit && is_get) ? OpAccessAckData : OpAccessAck;
         tld_q.d_data   <= hit ? rdata : '0;
      end
   end

   always_ff @(posedge clock) begin
      if (tick_reset_in) begin
         overflow_q <= 1'b0;
      end else if (push && full && !pop) begin
         overflow_q <= 1'b1;
      end else if (hit && is_put && (offset == RegStatus) && tick_tla.a_data[StatOverflow]) begin
         overflow_q <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (tick_reset_in) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         ser_tx_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else if (pop) begin
         state_q   <= StStart;
         timer_q   <= bit_last;
         bit_idx_q <= '0;
         shift_q   <= fifo_rdata;
         ser_tx_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= even_parity(fifo_rdata);
`endif
      end else if (state_q != StIdle) begin
         if (timer_q != '0) begin
            timer_q <= timer_q - 16'd1;
         end else begin
            timer_q <= bit_last;
            unique case (state_q)
               StStart: begin
                  ser_tx_q <= shift_q[0];
                  state_q  <= StData;
               end
               StData: begin
                  if (bit_idx_q == 3'd7) begin
                     bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                     ser_tx_q  <= parity_q;
                     state_q   <= StParity;
`else
                     ser_tx_q  <= 1'b1;
                     state_q   <= StStop;
`endif
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     shift_q   <= {1'b0, shift_q[7:1]};
                     ser_tx_q  <= shift_q[1];
                  end
               end
`ifdef UART_TX_PARITY_EN
               StParity: begin
                  ser_tx_q <= 1'b1;
                  state_q  <= StStop;
               end
`endif
               StStop:  state_q <= StIdle;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus_tld = tld_q;
   assign ser_tx  = ser_tx_q;
   assign tx_busy = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_tilelink_uart_tx.sv
// Directed bench for tilelink_uart_tx: register vectors, frame shapes, overflow and reset.
module tb_tilelink_uart_tx;
   import uart_tx_pkg::*;

   localparam int unsigned Cpb = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned FrameBits = 11;
`else
   localparam int unsigned FrameBits = 10;
`endif

   logic      clock = 1'b0;
   logic      tick_reset_in;
   tilelink_a tla;
   tilelink_d tld;
   logic      ser_tx, tx_busy;

   int n_checks = 0;
   int n_fail   = 0;
   logic [8:0] rx_q[$];

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      logic        valid;
      logic        exp_valid;
      logic [2:0]  exp_op;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[12];

   always #5 clock = ~clock;

   tilelink_uart_tx #(
      .addr_mask    (32'hF000_0000),
      .addr_tag     (32'h4000_0000),
      .clks_per_bit (Cpb),
      .fifo_depth   (8)
   ) dut (
      .clock         (clock),
      .tick_reset_in (tick_reset_in),
      .tick_tla      (tla),
      .bus_tld       (tld),
      .ser_tx        (ser_tx),
      .tx_busy       (tx_busy)
   );

   function automatic logic exp_par(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
      return ^b;
`else
      return 1'b0 & b[0];
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      tla.a_valid = 1'b0;
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask);
      tla.a_opcode  = op;
      tla.a_address = addr;
      tla.a_data    = data;
      tla.a_mask    = mask;
      tla.a_valid   = 1'b1;
   endtask

   // Samples one whole frame cycle by cycle; optionally reads STATUS at cycle status_at.
   task automatic expect_frame(input logic [7:0] b, input int status_at,
                               input logic [31:0] status_exp, input string name);
      logic [63:0] got, exp;
      logic [FrameBits-1:0] fb;
`ifdef UART_TX_PARITY_EN
      fb = {1'b1, ^b, b, 1'b0};
`else
      fb = {1'b1, b, 1'b0};
`endif
      got = '0;
      exp = '0;
      for (int i = 0; i < int'(FrameBits * Cpb); i++) begin
         if (i == status_at) drive(OpGet, 32'h4000_0004, 32'h0, 4'hF);
         tick();
         got[i] = ser_tx;
         exp[i] = fb[i / int'(Cpb)];
         if (i == status_at) check({name, " status"}, 64'(tld.d_data), 64'(status_exp));
      end
      check(name, got, exp);
   endtask

   task automatic check_rx(input logic [7:0] exp, input string name);
      logic [8:0] r;
      check({name, " rx present"}, 64'(rx_q.size() > 0), 64'd1);
      if (rx_q.size() > 0) begin
         r = rx_q.pop_front();
         check({name, " rx"}, 64'(r), 64'({exp_par(exp), exp}));
      end
   endtask

   // Simple UART receiver sampling mid-bit.
   initial begin
      logic [7:0] b;
      logic p;
      forever begin
         @(negedge ser_tx);
         repeat (Cpb / 2) @(posedge clock);
         #1;
         for (int k = 0; k < 8; k++) begin
            repeat (Cpb) @(posedge clock);
            #1;
            b[k] = ser_tx;
         end
         p = 1'b0;
`ifdef UART_TX_PARITY_EN
         repeat (Cpb) @(posedge clock);
         #1;
         p = ser_tx;
`endif
         repeat (Cpb) @(posedge clock);
         #1;
         rx_q.push_back({p, b});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      tla           = '0;
      tick_reset_in = 1'b1;
      repeat (3) tick();
      tick_reset_in = 1'b0;
      check("reset ser_tx", 64'(ser_tx), 64'd1);
      check("reset tx_busy", 64'(tx_busy), 64'd0);
      check("reset bus_tld", 64'(tld), 64'd0);

      vecs[0]  = '{OpGet, 32'h4000_0004, 32'h0, 4'hF, 1'b1, 1'b1, OpAccessAckData, 32'h1};
      vecs[1]  = '{OpGet, 32'h4000_0000, 32'h0, 4'hF, 1'b1, 1'b1, OpAccessAckData, 32'h0};
      vecs[2]  = '{OpGet, 32'h4000_0008, 32'h0, 4'hF, 1'b1, 1'b1, OpAccessAckData, 32'h0};
      vecs[3]  = '{OpGet, 32'h4000_000C, 32'h0, 4'hF, 1'b1, 1'b1, OpAccessAckData, 32'h0};
      vecs[4]  = '{OpPutFullData, 32'h4000_0008, 32'hFF, 4'hF, 1'b1, 1'b1, OpAccessAck, 32'h0};
      vecs[5]  = '{OpPutPartialData, 32'h4000_000C, 32'h1, 4'h1, 1'b1, 1'b1, OpAccessAck, 32'h0};
      vecs[6]  = '{OpPutFullData, 32'h8000_0000, 32'h11, 4'hF, 1'b1, 1'b0, OpAccessAck, 32'h0};
      vecs[7]  = '{OpGet, 32'h8000_0004, 32'h0, 4'hF, 1'b1, 1'b0, OpAccessAck, 32'h0};
      vecs[8]  = '{OpGet, 32'h4000_0004, 32'h0, 4'hF, 1'b0, 1'b0, OpAccessAck, 32'h0};
      vecs[9]  = '{OpPutPartialData, 32'h4000_0000, 32'h22, 4'hE, 1'b1, 1'b1, OpAccessAck, 32'h0};
      vecs[10] = '{OpPutFullData, 32'h4000_0004, 32'h8, 4'hF, 1'b1, 1'b1, OpAccessAck, 32'h0};
      vecs[11] = '{OpGet, 32'h4000_0014, 32'h0, 4'hF, 1'b1, 1'b1, OpAccessAckData, 32'h1};

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask);
         tla.a_valid = vecs[i].valid;
         tick();
         check($sformatf("vec%0d", i), 64'(tld),
               64'({vecs[i].exp_op, vecs[i].exp_data, vecs[i].exp_valid}));
      end
      tick();
      check("idle after vectors busy", 64'(tx_busy), 64'd0);
      check("idle after vectors rx", 64'(rx_q.size()), 64'd0);

      // Single frame 0x55
      drive(OpPutFullData, 32'h4000_0000, 32'h55, 4'h1);
      tick();
      check("put55 ack", 64'(tld), 64'({OpAccessAck, 32'h0, 1'b1}));
      expect_frame(8'h55, -1, 32'h0, "frame55");
      check("busy in last stop cycle", 64'(tx_busy), 64'd1);
      tick();
      check("busy after frame55", 64'(tx_busy), 64'd0);
      check_rx(8'h55, "frame55");

      // Back-to-back frames with STATUS read mid-frame
      drive(OpPutFullData, 32'h4000_0000, 32'h01, 4'h1);
      tick();
      drive(OpPutFullData, 32'h4000_0000, 32'h02, 4'h1);
      expect_frame(8'h01, 8, 32'h0000_0104, "frame01");
      expect_frame(8'h02, -1, 32'h0, "frame02");
      tick();
      check("busy after pair", 64'(tx_busy), 64'd0);
      check_rx(8'h01, "pair first");
      check_rx(8'h02, "pair second");

      // Overflow: ten pushes, nine survive
      for (int i = 0; i < 10; i++) begin
         drive(OpPutFullData, 32'h4000_0000, 32'(8'hA0 + i), 4'h1);
         tick();
      end
      drive(OpGet, 32'h4000_0004, 32'h0, 4'hF);
      tick();
      check("status overflow", 64'(tld.d_data), 64'h80E);
      drive(OpPutFullData, 32'h4000_0004, 32'h8, 4'hF);
      tick();
      drive(OpGet, 32'h4000_0004, 32'h0, 4'hF);
      tick();
      check("status cleared", 64'(tld.d_data), 64'h806);
      for (int c = 0; c < 1000 && tx_busy; c++) tick();
      check("drain timeout", 64'(tx_busy), 64'd0);
      check("overflow rx count", 64'(rx_q.size()), 64'd9);
      for (int i = 0; i < 9; i++) check_rx(8'hA0 + 8'(i), $sformatf("ovf byte%0d", i));

      // Reset in the middle of DATA
      drive(OpPutFullData, 32'h4000_0000, 32'h33, 4'h1);
      tick();
      drive(OpPutFullData, 32'h4000_0000, 32'h44, 4'h1);
      tick();
      repeat (12) tick();
      tick_reset_in = 1'b1;
      tick();
      check("midreset ser_tx", 64'(ser_tx), 64'd1);
      check("midreset bus_tld", 64'(tld), 64'd0);
      tick_reset_in = 1'b0;
      drive(OpGet, 32'h4000_0004, 32'h0, 4'hF);
      tick();
      check("midreset status", 64'(tld.d_data), 64'h1);
      lows = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (ser_tx !== 1'b1) lows++;
      end
      check("midreset quiet line", 64'(lows), 64'd0);
      check("midreset busy", 64'(tx_busy), 64'd0);
      rx_q.delete();

      // Parity-sensitive byte
      drive(OpPutFullData, 32'h4000_0000, 32'h07, 4'h1);
      tick();
      expect_frame(8'h07, -1, 32'h0, "frame07");
      tick();
      check("busy after frame07", 64'(tx_busy), 64'd0);
      check_rx(8'h07, "frame07");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
